ball_motion_ctrl: RTL

Sequences the ball's motion datapath: produces the 16-bit motion code {vy[7:0], vx[7:0]} (two's-complement int8 per axis, bit 7 = negative) that the ball block adds to its position every frame. Ramps velocity with acceleration/deceleration from four direction keys. Shares the ball between the keyboard player and an autopilot requester via a grant handshake. Sits between the USB key decoder and the ball block; runs on the system clock, updates on a frame tick strobe.

---
 rtl/ball_motion_ctrl.sv | 99 +++++++++
 1 files changed

// File: rtl/ball_motion_ctrl.sv
// ball_motion_ctrl: ramps ball velocity from keys or autopilot and emits the {vy, vx} motion code. Optional BALL_CTRL_BOOST_EN doubles the manual speed limit.
module ball_motion_ctrl #(
  parameter int MAX_SPEED   = 8,
  parameter int ACCEL       = 1,
  parameter int DECEL       = 1,
  parameter int IDLE_FRAMES = 120
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_tick,
  input  logic        key_up,
  input  logic        key_down,
  input  logic        key_left,
  input  logic        key_right,
  input  logic        key_boost,
  input  logic        auto_req,
  input  logic [7:0]  auto_vx,
  input  logic [7:0]  auto_vy,
  output logic        auto_gnt,
  output logic [15:0] motion_code,
  output logic [1:0]  mode
);
  typedef enum logic [1:0] {MANUAL = 2'd0, AUTO = 2'd1, YIELD = 2'd2} state_t;
  localparam logic signed [9:0] LIM  = 10'(MAX_SPEED);
  localparam logic signed [9:0] BLIM = 10'((2 * MAX_SPEED > 127) ? 127 : 2 * MAX_SPEED);
  localparam logic signed [9:0] AC   = 10'(ACCEL);
  localparam logic signed [9:0] DC   = 10'(DECEL);
  localparam logic [7:0]        IDLE = 8'(IDLE_FRAMES);
  state_t state, state_nx;
  logic signed [7:0] vx, vy, vx_nx, vy_nx;
  logic [7:0] idle_cnt, idle_nx;
  logic signed [9:0] lim_m, lim_s, tx, ty, sx, sy;
  logic any_key;
  // Zero target decays by DECEL without crossing 0; a velocity left above the limit
  // (after boost release) falls back by DECEL; otherwise approach the target by ACCEL.
  function automatic logic signed [9:0] step(input logic signed [9:0] v, t, lim);
    logic signed [9:0] s;
    s = (v > lim || v < -lim) ? DC : AC;
    if (t == 10'sd0) return (v > DC) ? v - DC : (v < -DC) ? v + DC : 10'sd0;
    return (v < t) ? ((v + s > t) ? t : v + s) : (v > t) ? ((v - s < t) ? t : v - s) : v;
  endfunction
  function automatic logic signed [9:0] clamp(input logic signed [9:0] a);
    return (a > LIM) ? LIM : (a < -LIM) ? -LIM : a;
  endfunction
`ifdef BALL_CTRL_BOOST_EN
  assign lim_m = key_boost ? BLIM : LIM;
`else
  logic unused_boost;
  assign lim_m = LIM;
  assign unused_boost = key_boost;
`endif
  // Velocity targets, per-tick step, and mode/idle next-state.
  always_comb begin
    any_key  = key_up | key_down | key_left | key_right;
    lim_s    = (state == MANUAL) ? lim_m : LIM;
    tx       = (state == AUTO) ? clamp({{2{auto_vx[7]}}, auto_vx}) : (state == YIELD) ? 10'sd0 :
               (key_right & ~key_left) ? lim_m : (key_left & ~key_right) ? -lim_m : 10'sd0;
    ty       = (state == AUTO) ? clamp({{2{auto_vy[7]}}, auto_vy}) : (state == YIELD) ? 10'sd0 :
               (key_down & ~key_up) ? lim_m : (key_up & ~key_down) ? -lim_m : 10'sd0;
    sx       = step({{2{vx[7]}}, vx}, tx, lim_s);
    sy       = step({{2{vy[7]}}, vy}, ty, lim_s);
    vx_nx    = frame_tick ? 8'(sx) : vx;
    vy_nx    = frame_tick ? 8'(sy) : vy;
    state_nx = state;
    idle_nx  = idle_cnt;
    case (state)
      MANUAL: if (frame_tick) begin
        idle_nx = any_key ? 8'd0 : (idle_cnt < IDLE) ? idle_cnt + 8'd1 : idle_cnt;
        if (!any_key && idle_cnt == IDLE && auto_req) state_nx = AUTO;
      end
      AUTO: begin
        state_nx = any_key ? MANUAL : !auto_req ? YIELD : AUTO;
        idle_nx  = any_key ? 8'd0 : idle_cnt;
      end
      YIELD: if (any_key || (frame_tick && vx == 8'sd0 && vy == 8'sd0)) begin
        state_nx = MANUAL;
        idle_nx  = 8'd0;
      end
      default: state_nx = MANUAL;
    endcase
  end
  // Registered state, velocities and grant.
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      state    <= MANUAL;
      vx       <= '0;
      vy       <= '0;
      idle_cnt <= '0;
      auto_gnt <= 1'b0;
    end else begin
      state    <= state_nx;
      vx       <= vx_nx;
      vy       <= vy_nx;
      idle_cnt <= idle_nx;
      auto_gnt <= (state_nx == AUTO);
    end
  assign motion_code = {vy, vx};
  assign mode        = state;
endmodule
